// File: rtl/raizing_gfx_arbiter.sv
// Shares one SDRAM bank read port among the sprite and three scroll fetch clients.
// Each client keeps a one-entry tagged result, so an unchanged address is served without a bank access.
module raizing_gfx_arbiter #(
    parameter int AW        = 22,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          DOWNLOADING,
    input  logic [3:0]    CS,
    input  logic [AW-1:0] ADDR0,
    input  logic [AW-1:0] ADDR1,
    input  logic [AW-1:0] ADDR2,
    input  logic [AW-1:0] ADDR3,
    output logic [31:0]   DOUT0,
    output logic [31:0]   DOUT1,
    output logic [31:0]   DOUT2,
    output logic [31:0]   DOUT3,
    output logic [3:0]    OK,
    output logic [AW-1:0] BA_ADDR,
    output logic          BA_RD,
    input  logic          BA_ACK,
    input  logic          BA_DOK,
    input  logic          BA_RDY,
    input  logic [15:0]   DATA_READ,
    output logic [1:0]    GRANT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [AW-1:0] w_addr [4];
    logic [AW-1:0] r_tag  [4];
    logic [31:0]   r_dout [4];
    logic [3:0]    r_valid;
    logic [1:0]    r_last;
    logic [AW-1:0] r_lat_addr;
    logic          r_cnt;
    logic [15:0]   r_buf;
    logic [3:0]    w_hit;
    logic [3:0]    w_pend;
    logic [1:0]    w_winner;
    logic          w_grant_go;
    logic          w_done;

    // Round-robin scans upward from the client after the last winner; fixed priority scans from 0.
    function automatic logic [1:0] pick_winner(input logic [3:0] pend, input logic [1:0] last,
                                               input bit fixed);
        logic [1:0] idx;
        logic       found;
        pick_winner = 2'd0;
        found       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = fixed ? 2'(k) : 2'(last + 2'(k + 1));
            if (!found && pend[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    assign w_addr[0] = ADDR0;
    assign w_addr[1] = ADDR1;
    assign w_addr[2] = ADDR2;
    assign w_addr[3] = ADDR3;
    assign DOUT0     = r_dout[0];
    assign DOUT1     = r_dout[1];
    assign DOUT2     = r_dout[2];
    assign DOUT3     = r_dout[3];

    // Hit/pending per client from the tag registers and the live request.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_hit[i] = r_valid[i] & (r_tag[i] == w_addr[i]);
        end
        w_pend   = CS & ~w_hit;
        OK       = CS & w_hit;
        w_winner = pick_winner(w_pend, r_last, FIXED_PRI);
    end

    // Next-state logic; a short burst (RDY before the second word) drops the fetch.
    always_comb begin
        w_state_nx = r_state;
        w_grant_go = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!DOWNLOADING && (|w_pend)) begin
                    w_grant_go = 1'b1;
                    w_state_nx = ST_REQ;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (BA_ACK) begin
                    w_state_nx = ST_DATA;
                end else begin
                    w_state_nx = ST_REQ;
                end
            end
            ST_DATA: begin
                if (BA_DOK && r_cnt) begin
                    w_done     = 1'b1;
                    w_state_nx = ST_IDLE;
                end else if (BA_RDY) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_DATA;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Bank handshake, word assembly and the granted client's result write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BA_RD      <= 1'b0;
            BA_ADDR    <= '0;
            GRANT      <= 2'd0;
            r_last     <= 2'd3;
            r_lat_addr <= '0;
            r_cnt      <= 1'b0;
            r_buf      <= 16'h0000;
            r_valid    <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                r_tag[i]  <= '0;
                r_dout[i] <= 32'h0000_0000;
            end
        end else begin
            if (w_grant_go) begin
                GRANT      <= w_winner;
                r_last     <= w_winner;
                r_lat_addr <= w_addr[w_winner];
                BA_ADDR    <= w_addr[w_winner];
                BA_RD      <= 1'b1;
                r_cnt      <= 1'b0;
            end
            if (r_state == ST_REQ && BA_ACK) begin
                BA_RD <= 1'b0;
            end
            if (r_state == ST_DATA && BA_DOK && !r_cnt) begin
                r_buf <= DATA_READ;
                r_cnt <= 1'b1;
            end
            if (w_done) begin
                r_dout[GRANT] <= {DATA_READ, r_buf};
                r_tag[GRANT]  <= r_lat_addr;
            end
            // A ROM download invalidates everything, including a fetch finishing this cycle.
            for (int i = 0; i < 4; i++) begin
                if (DOWNLOADING) begin
                    r_valid[i] <= 1'b0;
                end else if (w_done && GRANT == 2'(i)) begin
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_raizing_gfx_arbiter.sv
// Self-checking bench for raizing_gfx_arbiter: scripted bank responses with a fetch scoreboard.
module tb_raizing_gfx_arbiter;

    localparam int AW = 22;

    typedef struct {
        logic [1:0]  g;
        logic [31:0] d;
    } exp_t;

    logic          CLK;
    logic          RESET;
    logic          DOWNLOADING;
    logic [3:0]    CS;
    logic [AW-1:0] addr [4];
    logic [31:0]   dout [4];
    logic [3:0]    OK;
    logic [AW-1:0] BA_ADDR;
    logic          BA_RD;
    logic          BA_ACK;
    logic          BA_DOK;
    logic          BA_RDY;
    logic [15:0]   DATA_READ;
    logic [1:0]    GRANT;

    logic [31:0]   f_dout [4];
    logic [3:0]    f_ok;
    logic [AW-1:0] f_ba_addr;
    logic          f_ba_rd;
    logic [1:0]    f_grant;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   lat;

    raizing_gfx_arbiter #(.AW(AW), .FIXED_PRI(1'b0)) u_dut (
        .CLK(CLK), .RESET(RESET), .DOWNLOADING(DOWNLOADING), .CS(CS),
        .ADDR0(addr[0]), .ADDR1(addr[1]), .ADDR2(addr[2]), .ADDR3(addr[3]),
        .DOUT0(dout[0]), .DOUT1(dout[1]), .DOUT2(dout[2]), .DOUT3(dout[3]),
        .OK(OK), .BA_ADDR(BA_ADDR), .BA_RD(BA_RD), .BA_ACK(BA_ACK), .BA_DOK(BA_DOK),
        .BA_RDY(BA_RDY), .DATA_READ(DATA_READ), .GRANT(GRANT)
    );

    raizing_gfx_arbiter #(.AW(AW), .FIXED_PRI(1'b1)) u_fix (
        .CLK(CLK), .RESET(RESET), .DOWNLOADING(DOWNLOADING), .CS(CS),
        .ADDR0(addr[0]), .ADDR1(addr[1]), .ADDR2(addr[2]), .ADDR3(addr[3]),
        .DOUT0(f_dout[0]), .DOUT1(f_dout[1]), .DOUT2(f_dout[2]), .DOUT3(f_dout[3]),
        .OK(f_ok), .BA_ADDR(f_ba_addr), .BA_RD(f_ba_rd), .BA_ACK(BA_ACK), .BA_DOK(BA_DOK),
        .BA_RDY(BA_RDY), .DATA_READ(DATA_READ), .GRANT(f_grant)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // One fetch: wait for the grant, ACK after ack_delay cycles, return two words.
    // hook 1 moves ADDR2 to 0x20 mid-DATA; hook 2 raises DOWNLOADING mid-DATA.
    task automatic fetch(input logic [1:0] eg, input logic [15:0] w0, input logic [15:0] w1,
                         input int ack_delay, input int hook, output int lt);
        exp_t e;
        lt = 0;
        do begin
            @(negedge CLK);
            lt++;
        end while (!BA_RD && lt < 20);
        check("ba_rd_up", BA_RD, 1'b1);
        check("grant", GRANT, eg);
        check("ba_addr", BA_ADDR, addr[eg]);
        e.g = eg;
        e.d = {w1, w0};
        sb.push_back(e);
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge CLK);
            check("ba_rd_hold", BA_RD, 1'b1);
        end
        BA_ACK = 1'b1;
        @(negedge CLK);
        BA_ACK = 1'b0;
        check("ba_rd_drop", BA_RD, 1'b0);
        BA_DOK    = 1'b1;
        DATA_READ = w0;
        if (hook == 1) addr[2] = 22'h000020;
        if (hook == 2) DOWNLOADING = 1'b1;
        @(negedge CLK);
        DATA_READ = w1;
        @(negedge CLK);
        BA_DOK    = 1'b0;
        DATA_READ = 16'h0000;
        e = sb.pop_front();
        check("dout", dout[e.g], e.d);
    endtask

    initial begin
        RESET       = 1'b1;
        DOWNLOADING = 1'b0;
        CS          = 4'b0000;
        BA_ACK      = 1'b0;
        BA_DOK      = 1'b0;
        BA_RDY      = 1'b0;
        DATA_READ   = 16'h0000;
        for (int i = 0; i < 4; i++) addr[i] = 22'h0;
        repeat (3) @(negedge CLK);
        check("rst_ba_rd", BA_RD, 1'b0);
        check("rst_ba_addr", BA_ADDR, 22'h0);
        check("rst_grant", GRANT, 2'd0);
        check("rst_ok", OK, 4'b0000);
        check("rst_dout0", dout[0], 32'h0);
        RESET = 1'b0;

        // Single miss with ACK on the third request cycle.
        addr[0] = 22'h000100;
        CS      = 4'b0001;
        fetch(2'd0, 16'h1111, 16'h2222, 2, 0, lat);
        check("miss_lat", lat, 1);
        check("miss_ok", OK, 4'b0001);
        check("miss_dout0", dout[0], 32'h2222_1111);

        // Hit reuse after CS drops and returns.
        CS = 4'b0000;
        #1 check("hit_cs_low_ok", OK, 4'b0000);
        @(negedge CLK);
        CS = 4'b0001;
        #1 check("hit_ok", OK, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("hit_no_rd", BA_RD, 1'b0);
        end

        // Round-robin with all clients missing every fetch; fixed instance must stay on 0.
        CS = 4'b0000;
        do_reset();
        CS = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) addr[i] = 22'(32'h2000 + k * 4 + i);
            fetch(2'(k % 4), 16'(32'h1000 + k), 16'(32'h2000 + k), 1, 0, lat);
            check("rr_lat", lat, 1);
            check("rr_ok", OK[k % 4], 1'b1);
            check("fix_grant", f_grant, 2'd0);
            check("fix_dout0", f_dout[0], {16'(32'h2000 + k), 16'(32'h1000 + k)});
        end

        // Address change during DATA: result lands under the old tag, then a refetch.
        CS = 4'b0000;
        do_reset();
        addr[2] = 22'h000010;
        CS      = 4'b0100;
        fetch(2'd2, 16'haaaa, 16'hbbbb, 1, 1, lat);
        check("chg_ok_low", OK, 4'b0000);
        fetch(2'd2, 16'hcccc, 16'hdddd, 0, 0, lat);
        check("chg_refetch_lat", lat, 1);
        check("chg_ok_high", OK, 4'b0100);

        // DOWNLOADING raised mid-DATA: burst completes, nothing becomes valid, no grants.
        addr[0] = 22'h000300;
        CS      = 4'b0001;
        fetch(2'd0, 16'h3333, 16'h4444, 0, 2, lat);
        check("dl_ok_low", OK, 4'b0000);
        CS = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("dl_no_rd", BA_RD, 1'b0);
            check("dl_ok", OK, 4'b0000);
        end
        DOWNLOADING = 1'b0;
        fetch(2'd2, 16'h5555, 16'h6666, 0, 0, lat);
        fetch(2'd0, 16'h7777, 16'h8888, 0, 0, lat);
        check("dl_refetch_ok", OK, 4'b0101);

        // Reset while a request is outstanding; stray DOK afterwards is ignored.
        addr[1] = 22'h000400;
        CS      = 4'b0010;
        @(negedge CLK);
        check("rq_rd_up", BA_RD, 1'b1);
        RESET = 1'b1;
        CS    = 4'b0000;
        @(negedge CLK);
        RESET = 1'b0;
        check("rq_rst_rd", BA_RD, 1'b0);
        check("rq_rst_ok", OK, 4'b0000);
        check("rq_rst_grant", GRANT, 2'd0);
        BA_DOK    = 1'b1;
        DATA_READ = 16'hdead;
        repeat (2) @(negedge CLK);
        BA_DOK = 1'b0;
        for (int i = 0; i < 4; i++) check("rq_stray_dout", dout[i], 32'h0);
        CS = 4'b1111;
        #1 check("rq_valid_clr", OK, 4'b0000);
        CS = 4'b0000;

        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
